// File: rtl/spi_reg_bank_if.sv
// Byte-level bus between the SPI slave shifter and the register bank.
// The master side owns frame select and receive strobe.
interface spi_reg_bank_if;
  logic       ce0;
  logic       ssig;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [3:0] leds;
  logic       frame_err;

  modport master (
    output ce0, ssig, rx_data,
    input  tx_data, leds, frame_err
  );

  modport slave (
    input  ce0, ssig, rx_data,
    output tx_data, leds, frame_err
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-addressed 8x8 register bank with burst access,
// frame counter, read-only ID and sticky framing error.
module spi_reg_bank #(
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter logic [3:0] LED_RESET = 4'b0000
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] regs_q [6];
  logic [7:0] regs_d [6];
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] baddr_q, baddr_d;
  logic [2:0] cur_q, cur_d;
  logic       wr_q, wr_d;
  logic       dseen_q, dseen_d;
  logic       err_q, err_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] leds_q;
  logic [7:0] bank [8];
  logic [2:0] nxt;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      bank[i] = regs_q[i];
    end
    bank[6] = cnt_q;
    bank[7] = ID_VALUE;
  end

  assign nxt = baddr_q + 3'd1;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    cnt_d   = cnt_q;
    baddr_d = baddr_q;
    cur_d   = cur_q;
    wr_d    = wr_q;
    dseen_d = dseen_q;
    err_d   = err_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.ce0) state_d = CMD;
      end
      CMD: begin
        if (bus.ce0) begin
          state_d = IDLE;
        end else if (bus.ssig) begin
          state_d = DATA;
          wr_d    = bus.rx_data[7];
          baddr_d = bus.rx_data[2:0];
          cur_d   = bus.rx_data[2:0];
          dseen_d = 1'b0;
          tx_d    = bank[bus.rx_data[2:0]];
        end
      end
      DATA: begin
        // A strobe coincident with frame close is dropped.
        if (bus.ce0) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 8'd1;
          if (!dseen_q) err_d = 1'b1;
        end else if (bus.ssig) begin
          dseen_d = 1'b1;
          cur_d   = baddr_q;
          baddr_d = nxt;
          if (wr_q) begin
            for (int i = 0; i < 6; i++) begin
              if (baddr_q == 3'(i)) regs_d[i] = bus.rx_data;
            end
            tx_d = bus.rx_data;
          end else begin
            tx_d = bank[nxt];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outside a data phase the master reads back status.
    if (state_d != DATA) tx_d = {err_d, 4'b0000, cur_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 6; i++) begin
        regs_q[i] <= 8'h00;
      end
      regs_q[0] <= {4'h0, LED_RESET};
      cnt_q   <= 8'h00;
      baddr_q <= 3'd0;
      cur_q   <= 3'd0;
      wr_q    <= 1'b0;
      dseen_q <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= 8'h00;
      leds_q  <= LED_RESET;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      cnt_q   <= cnt_d;
      baddr_q <= baddr_d;
      cur_q   <= cur_d;
      wr_q    <= wr_d;
      dseen_q <= dseen_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      leds_q  <= regs_q[0][3:0];
    end
  end

  assign bus.tx_data   = tx_q;
  assign bus.leds      = leds_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed plus randomized frames against a byte-level
// reference model of the register bank.
module tb_spi_reg_bank;

  logic clk = 1'b0;
  logic rst_n;

  spi_reg_bank_if bus ();

  spi_reg_bank #(
    .ID_VALUE  (8'hA5),
    .LED_RESET (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_regs [8];
  logic       m_err;
  logic [2:0] m_cur;
  logic [2:0] m_ptr;
  logic       m_wr;
  int         m_nb;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_regs[7] = 8'hA5;
    m_err = 1'b0;
    m_cur = 3'd0;
    m_ptr = 3'd0;
    m_wr  = 1'b0;
    m_nb  = 0;
  endtask

  function automatic logic [7:0] status();
    return {m_err, 4'b0000, m_cur};
  endfunction

  task automatic open_f();
    bus.ce0 = 1'b0;
    tick();
    m_nb = 0;
    chk("open_status", bus.tx_data, status());
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] exp;
    bus.ssig    = 1'b1;
    bus.rx_data = b;
    tick();
    bus.ssig    = 1'b0;
    bus.rx_data = 8'($urandom);
    if (m_nb == 0) begin
      m_wr  = b[7];
      m_ptr = b[2:0];
      m_cur = m_ptr;
      exp   = m_regs[m_ptr];
    end else begin
      m_cur = m_ptr;
      if (m_wr) begin
        if (m_ptr < 3'd6) m_regs[m_ptr] = b;
        exp = b;
      end else begin
        exp = m_regs[(int'(m_ptr) + 1) % 8];
      end
      m_ptr = 3'((int'(m_ptr) + 1) % 8);
    end
    m_nb++;
    chk("tx_after_byte", bus.tx_data, exp);
  endtask

  task automatic close_f(input logic stray);
    bus.ce0     = 1'b1;
    bus.ssig    = stray;
    bus.rx_data = 8'hFF;
    tick();
    bus.ssig = 1'b0;
    if (m_nb == 1) m_err = 1'b1;
    if (m_nb > 0) m_regs[6] = m_regs[6] + 8'd1;
    m_nb = 0;
    chk("close_status", bus.tx_data, status());
    chk("frame_err", {7'b0, bus.frame_err}, {7'b0, m_err});
    chk("leds", {4'b0, bus.leds}, {4'b0, m_regs[0][3:0]});
  endtask

  task automatic read_all(input logic [2:0] start);
    open_f();
    send({5'b00000, start});
    for (int i = 0; i < 8; i++) send(8'($urandom));
    close_f(1'b0);
  endtask

  initial begin
    bus.ce0     = 1'b1;
    bus.ssig    = 1'b0;
    bus.rx_data = 8'h00;
    rst_n       = 1'b0;
    m_reset();
    #12;
    chk("rst_tx", bus.tx_data, 8'h00);
    chk("rst_leds", {4'b0, bus.leds}, 8'h00);
    chk("rst_err", {7'b0, bus.frame_err}, 8'h00);
    rst_n = 1'b1;
    tick();

    // empty frame must not count
    open_f();
    close_f(1'b0);

    open_f();
    send(8'h82);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    close_f(1'b0);
    chk("burst_reg6", m_regs[6], 8'h01);
    read_all(3'd0);

    open_f();
    send(8'h07);
    send(8'h00);
    send(8'h00);
    close_f(1'b0);

    open_f();
    send(8'h86);
    send(8'h55);
    close_f(1'b0);
    open_f();
    send(8'h80);
    send(8'h0F);
    close_f(1'b0);
    chk("leds_F", {4'b0, bus.leds}, 8'h0F);
    read_all(3'd5);

    open_f();
    send(8'h81);
    close_f(1'b0);
    chk("abort_bit7", {7'b0, bus.tx_data[7]}, 8'h01);
    read_all(3'd1);

    // strobe with frame select high
    bus.ssig    = 1'b1;
    bus.rx_data = 8'h5A;
    tick();
    bus.ssig = 1'b0;
    chk("stray_idle", bus.tx_data, status());
    open_f();
    send(8'h83);
    send(8'h44);
    close_f(1'b1);
    read_all(3'd2);

    for (int n = 0; n < 6; n++) begin
      int len;
      len = int'($urandom_range(1, 5));
      open_f();
      send({1'b1, 4'($urandom), 3'($urandom)});
      for (int k = 0; k < len; k++) send(8'($urandom));
      close_f(1'b0);
      read_all(3'($urandom));
    end

    open_f();
    send(8'h85);
    send(8'h9A);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", bus.tx_data, 8'h00);
    chk("midrst_leds", {4'b0, bus.leds}, 8'h00);
    chk("midrst_err", {7'b0, bus.frame_err}, 8'h00);
    m_reset();
    #3;
    rst_n = 1'b1;
    tick();
    chk("rel_status", bus.tx_data, status());
    send(8'h83);
    send(8'h77);
    close_f(1'b0);
    read_all(3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter ID_VALUE, default 8'hA5, constant returned when register 7 is read.
REQ-002 Parameter LED_RESET, default 4'b0000, reset value of register 0 bits [3:0].
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ce0  input  1  SPI frame select, active-low, already synchronised to clk; high means no frame.
REQ-006 ssig  input  1  one-clk strobe from the SPI slave stage, meaning a full byte has been received on rx_data.
REQ-007 rx_data  input  8  received byte, valid only in the ssig cycle.
REQ-008 tx_data  output  8  byte for the SPI slave stage to shift out on the next byte slot; registered.
REQ-009 leds  output  4  register 0 bits [3:0], registered.
REQ-010 frame_err  output  1  sticky flag: a frame ended with a command byte but no data byte.

Function
REQ-011 Register file of 8 x 8 bits, addresses 0-7:
- 0-5: read/write.
- 6: read-only frame counter.
- 7: read-only, reads ID_VALUE.
REQ-012 State machine states:
- IDLE: ce0 high.
- CMD: frame open, awaiting command byte.
- DATA: command accepted, transferring data bytes.
REQ-013 Transitions:
- IDLE->CMD on ce0 low.
- CMD->DATA on ssig.
- DATA->DATA on ssig.
- Any state->IDLE on ce0 high.
REQ-014 Command byte fields: bit7 = 1 for write, 0 for read; bits [2:0] = start address; bits [6:3] ignored.
REQ-015 Burst address: after each data byte strobe in DATA, the address increments by 1, wrapping 7->0.
REQ-016 Write: each data byte is written to reg[addr] in the ssig cycle; writes to addresses 6 and 7 are silently discarded.
REQ-017 Read tx_data timing:
- One clk after the command-byte ssig, tx_data = reg[start address].
- One clk after each data-byte ssig, tx_data = reg[next address].
REQ-018 In IDLE and CMD, tx_data = {frame_err, 4'b0000, cur_addr[2:0]}, where cur_addr is the last address used, 0 after reset.
REQ-019 During a write burst, tx_data = the last rx_data written, so the master sees an echo one byte later.
REQ-020 Frame counter (reg 6):
- Increments by 1 on each ce0 rising edge whose frame carried at least one ssig.
- Wraps 255->0.
- Empty frames (ce0 low then high, no ssig) do not count.
REQ-021 frame_err is set on a ce0 rising edge while in DATA with zero data bytes received; it is cleared only by rst_n.
REQ-022 ssig while ce0 is high is ignored: no state change, write, counter change or tx_data change.
REQ-023 ssig in the same cycle as ce0 rising is ignored as in REQ-022, and the state goes to IDLE.
REQ-024 ce0 rising mid-burst ends the frame: completed writes are kept, the burst address is discarded, and the next frame needs a new command byte.
REQ-025 ssig asserted on consecutive cycles: each cycle is processed as a separate byte.
REQ-026 leds tracks reg0[3:0] with one clk latency from the write.

Reset
REQ-027 On rst_n low, asynchronously:
- state = IDLE.
- regs 0-5 = 8'h00, except reg0[3:0] = LED_RESET.
- reg 6 = 8'h00.
- cur_addr = 0.
- frame_err = 0.
- tx_data = 8'h00.
- leds = LED_RESET.
REQ-028 Reset release takes effect at the first clk edge with rst_n high; a frame already open at release (ce0 low) is entered at CMD on that edge.

Verification
REQ-029 Write burst: frame with bytes 0x82, 0x11, 0x22, 0x33 -> reg2=0x11, reg3=0x22, reg4=0x33; reg6=1 after ce0 high.
REQ-030 Read with wrap: frame with bytes 0x07, 0x00, 0x00 -> tx_data 0xA5 after byte 1, then reg0 after byte 2; address wraps 7->0.
REQ-031 Read-only and LEDs: frame with 0x86, 0x55 -> reg6 unchanged by the write; then frame with 0x80, 0x0F -> leds=4'hF.
REQ-032 Aborted frame: frame with 0x81 only, then ce0 high -> frame_err=1, reg1 unchanged, reg6 incremented, status tx_data bit7=1.
REQ-033 Stray strobes: ssig with ce0 high, and ssig coincident with ce0 rising -> no register, counter or tx_data change.
REQ-034 Reset mid-burst: rst_n low after the second byte of a write burst -> all outputs at reset values within the same cycle; after release, the next frame needs a new command byte.
